if_fetch: RTL

//  Instruction-fetch stage: owns the PC, issues requests to instruction memory, buffers returned words and

---
 rtl/if_fetch.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request at a time
// to instruction memory, and presents returned words to the IF/ID register.
// Fetched JALs may redirect the next fetch (static taken prediction).
// Redirect priority: switch (trap) > flush (branch) > halt (stall).
module if_fetch #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter bit          PREDICT_JAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        flush,
  input  logic [63:0] flush_pc,
  input  logic        switch,
  input  logic [63:0] switch_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] IF_pc,
  output logic [31:0] IF_ins,
  output logic [63:0] IF_pc4,
  output logic        IF_valid,
  output logic        IF_jump
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_pc, w_pc_nxt;

  // Output slot (drives IF_* directly)
  logic        r_slot_valid, w_slot_valid_nxt;
  logic [63:0] r_slot_pc, w_slot_pc_nxt;
  logic [63:0] r_slot_pc4, w_slot_pc4_nxt;
  logic [31:0] r_slot_ins, w_slot_ins_nxt;
  logic        r_slot_jump, w_slot_jump_nxt;

  // Single-entry hold buffer; its occupancy is implied by S_HOLD
  logic [63:0] r_hold_pc, w_hold_pc_nxt;
  logic [31:0] r_hold_ins, w_hold_ins_nxt;
  logic        r_hold_jump, w_hold_jump_nxt;

  logic        w_is_jal;
  logic [63:0] w_jal_off;
  logic [63:0] w_pc_seq;
  logic [63:0] w_pc_word_nxt;
  logic        w_redirect;
  logic [63:0] w_redir_sel;
  logic [63:0] w_redir_pc;
  logic        w_slot_free;

  assign w_is_jal      = PREDICT_JAL && (imem_rdata[6:0] == 7'b1101111);
  assign w_jal_off     = {{43{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                          imem_rdata[20], imem_rdata[30:21], 1'b0};
  assign w_pc_seq      = r_pc + 64'd4;
  assign w_pc_word_nxt = w_is_jal ? (r_pc + w_jal_off) : w_pc_seq;
  assign w_redirect    = switch | flush;
  assign w_redir_sel   = switch ? switch_pc : flush_pc;
  assign w_redir_pc    = w_redir_sel & ~64'h3;
  // Slot can take a new word if empty now or being consumed at this edge
  assign w_slot_free   = !r_slot_valid || !halt;

  assign imem_req  = rst && (r_state == S_REQ);
  assign imem_addr = r_pc;

  assign IF_valid = r_slot_valid;
  assign IF_pc    = r_slot_pc;
  assign IF_pc4   = r_slot_pc4;
  assign IF_ins   = r_slot_ins;
  assign IF_jump  = r_slot_jump;

  // State, PC, output slot and hold buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_slot_valid <= 1'b0;
      r_slot_pc    <= '0;
      r_slot_pc4   <= '0;
      r_slot_ins   <= '0;
      r_slot_jump  <= 1'b0;
      r_hold_pc    <= '0;
      r_hold_ins   <= '0;
      r_hold_jump  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_slot_valid <= w_slot_valid_nxt;
      r_slot_pc    <= w_slot_pc_nxt;
      r_slot_pc4   <= w_slot_pc4_nxt;
      r_slot_ins   <= w_slot_ins_nxt;
      r_slot_jump  <= w_slot_jump_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
      r_hold_ins   <= w_hold_ins_nxt;
      r_hold_jump  <= w_hold_jump_nxt;
    end
  end

  // Next-state, next-PC and slot/buffer update; redirects override the normal flow
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_slot_valid_nxt = r_slot_valid;
    w_slot_pc_nxt    = r_slot_pc;
    w_slot_pc4_nxt   = r_slot_pc4;
    w_slot_ins_nxt   = r_slot_ins;
    w_slot_jump_nxt  = r_slot_jump;
    w_hold_pc_nxt    = r_hold_pc;
    w_hold_ins_nxt   = r_hold_ins;
    w_hold_jump_nxt  = r_hold_jump;

    // Slot is consumed on every non-halted edge unless reloaded below
    if (!halt) begin
      w_slot_valid_nxt = 1'b0;
      w_slot_pc_nxt    = '0;
      w_slot_pc4_nxt   = '0;
      w_slot_ins_nxt   = '0;
      w_slot_jump_nxt  = 1'b0;
    end

    case (r_state)
      S_REQ: begin
        if (imem_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_pc_nxt = w_pc_word_nxt;
          if (w_slot_free) begin
            w_slot_valid_nxt = 1'b1;
            w_slot_pc_nxt    = r_pc;
            w_slot_pc4_nxt   = w_pc_seq;
            w_slot_ins_nxt   = imem_rdata;
            w_slot_jump_nxt  = w_is_jal;
            w_state_nxt      = S_REQ;
          end else begin
            w_hold_pc_nxt    = r_pc;
            w_hold_ins_nxt   = imem_rdata;
            w_hold_jump_nxt  = w_is_jal;
            w_state_nxt      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!halt) begin
          w_slot_valid_nxt = 1'b1;
          w_slot_pc_nxt    = r_hold_pc;
          w_slot_pc4_nxt   = r_hold_pc + 64'd4;
          w_slot_ins_nxt   = r_hold_ins;
          w_slot_jump_nxt  = r_hold_jump;
          w_state_nxt      = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase

    // A redirect discards everything buffered; a request still in flight
    // (or accepted on this very edge) must have its response dropped.
    if (w_redirect) begin
      w_pc_nxt         = w_redir_pc;
      w_slot_valid_nxt = 1'b0;
      w_slot_pc_nxt    = '0;
      w_slot_pc4_nxt   = '0;
      w_slot_ins_nxt   = '0;
      w_slot_jump_nxt  = 1'b0;
      w_hold_pc_nxt    = '0;
      w_hold_ins_nxt   = '0;
      w_hold_jump_nxt  = 1'b0;
      case (r_state)
        S_REQ:          w_state_nxt = imem_ready  ? S_DROP : S_REQ;
        S_WAIT, S_DROP: w_state_nxt = imem_rvalid ? S_REQ  : S_DROP;
        default:        w_state_nxt = S_REQ;
      endcase
    end
  end

endmodule
